// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues credit-limited requests to instruction
// memory, buffers in-order responses in a small FIFO and hands them to decode.
// Redirects flush the buffer and mark still-outstanding responses as stale.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fpc;
  logic [31:0]   rpc;
  logic [CW-1:0] outst;
  logic [CW-1:0] disc;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic [CW:0]   credit_used;
  logic [31:0]   redirect_aligned;
  logic          grant;
  logic          drop;
  logic          push;
  logic          pop;
  logic          not_empty;

  // Circular pointer advance that also works for non-power-of-two depths.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Requests in flight plus buffered words may never exceed the buffer size,
  // so every returning response is guaranteed a slot.
  assign credit_used      = {1'b0, outst} + {1'b0, count};
  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign not_empty        = (count != '0);

  assign imem_req  = rst_n & ~redirect_valid & (credit_used < {1'b0, DEPTH_C});
  assign imem_addr = fpc;
  assign grant     = imem_req & imem_gnt;

  // A response is discarded when it belongs to a flushed stream.
  assign drop = imem_rvalid & (redirect_valid | (disc != '0));
  assign push = imem_rvalid & ~drop;

  assign id_valid = not_empty & ~redirect_valid;
  assign pop      = id_valid & id_ready;
  assign id_pc    = not_empty ? pc_mem[rd_ptr]    : '0;
  assign id_instr = not_empty ? instr_mem[rd_ptr] : '0;

  // Fetch PC advances on every accepted request and jumps on redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc <= RESET_PC;
    end else if (redirect_valid) begin
      fpc <= redirect_aligned;
    end else if (grant) begin
      fpc <= fpc + 32'd4;
    end
  end

  // Response PC tracks the address of the next word that will be buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpc <= RESET_PC;
    end else if (redirect_valid) begin
      rpc <= redirect_aligned;
    end else if (push) begin
      rpc <= rpc + 32'd4;
    end
  end

  // Outstanding counter: grant adds one, response removes one, both cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst <= '0;
    end else begin
      case ({grant, imem_rvalid})
        2'b10:   outst <= outst + CW'(1);
        2'b01:   outst <= outst - CW'(1);
        default: outst <= outst;
      endcase
    end
  end

  // Discard counter: a redirect marks every still-pending response as stale,
  // excluding one that is returning (and being dropped) in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disc <= '0;
    end else if (redirect_valid) begin
      disc <= imem_rvalid ? (outst - CW'(1)) : outst;
    end else if (imem_rvalid && (disc != '0)) begin
      disc <= disc - CW'(1);
    end
  end

  // FIFO control: pointers and occupancy, cleared by redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: the pc/instr pair is written at the tail on every push.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= rpc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a small in-order memory responder.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready = 1'b0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        memq [$];
  logic [31:0] obs_pc [$];
  logic [31:0] obs_instr [$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nreq = 0;
  logic gnt_en = 1'b1;
  logic resp_en = 1'b1;

  instr_fetch #(
    .RESET_PC(32'h0000_0000),
    .DEPTH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .id_valid(id_valid),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .id_ready(id_ready)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Contents of instruction memory at a given address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F1E;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: memory answers due requests in order, grants are recorded,
  // decode handshakes are logged; returns at posedge+1.
  task automatic applyStimulus();
    req_t r;
    if (resp_en && memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(memq[0].addr);
      memq.delete(0);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    imem_gnt = gnt_en;
    #1;
    if (imem_req && imem_gnt) begin
      r.addr = imem_addr;
      r.due  = cyc + 1;
      memq.push_back(r);
      nreq++;
    end
    if (id_valid && id_ready) begin
      obs_pc.push_back(id_pc);
      obs_instr.push_back(id_instr);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic doReset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b0;
    imem_gnt       = 1'b0;
    memq.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    obs_pc.delete();
    obs_instr.delete();
    nreq  = 0;
    rst_n = 1'b1;
  endtask

  task automatic waitObs(input int n, input int budget);
    int k;
    k = 0;
    while (obs_pc.size() < n && k < budget) begin
      applyStimulus();
      k++;
    end
    checkOutput("obs_count", 32'(obs_pc.size() >= n ? n : obs_pc.size()), 32'(n));
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    id_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("rst_id_valid", 32'(id_valid), 32'd0);
    checkOutput("rst_id_pc", id_pc, 32'h0);
    checkOutput("rst_id_instr", id_instr, 32'h0);
    checkOutput("rst_imem_addr", imem_addr, 32'h0);

    rst_n = 1'b1;
    #1;
    checkOutput("first_req", 32'(imem_req), 32'd1);
    checkOutput("first_addr", imem_addr, 32'h0);

    $display("[TB] streaming from reset");
    waitObs(8, 60);
    for (int i = 0; i < 8; i++) begin
      if (i < obs_pc.size()) begin
        checkOutput("stream_pc", obs_pc[i], 32'(4 * i));
        checkOutput("stream_instr", obs_instr[i], mem_word(32'(4 * i)));
      end
    end

    $display("[TB] decode stall fills buffer");
    doReset();
    id_ready = 1'b0;
    repeat (5) applyStimulus();
    checkOutput("stall_pc_stable", id_pc, 32'h0);
    repeat (5) applyStimulus();
    checkOutput("stall_nreq", 32'(nreq), 32'd2);
    checkOutput("stall_id_valid", 32'(id_valid), 32'd1);
    checkOutput("stall_id_pc", id_pc, 32'h0);
    checkOutput("stall_id_instr", id_instr, mem_word(32'h0));
    checkOutput("stall_no_req", 32'(imem_req), 32'd0);
    id_ready = 1'b1;
    applyStimulus();
    checkOutput("drain_head", id_pc, 32'h4);
    checkOutput("resume_req", 32'(imem_req), 32'd1);
    checkOutput("resume_addr", imem_addr, 32'h8);
    applyStimulus();
    checkOutput("drain_n", 32'(obs_pc.size()), 32'd2);
    if (obs_pc.size() >= 2) begin
      checkOutput("drain_pc0", obs_pc[0], 32'h0);
      checkOutput("drain_pc1", obs_pc[1], 32'h4);
    end

    $display("[TB] redirect with two outstanding");
    doReset();
    resp_en        = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    applyStimulus();
    redirect_valid = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("two_out_nreq", 32'(nreq), 32'd2);
    checkOutput("two_out_block", 32'(imem_req), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    applyStimulus();
    redirect_valid = 1'b0;
    #1;
    checkOutput("redir_addr", imem_addr, 32'h100);
    checkOutput("redir_no_credit", 32'(imem_req), 32'd0);
    resp_en = 1'b1;
    waitObs(1, 20);
    if (obs_pc.size() >= 1) begin
      checkOutput("redir_first_pc", obs_pc[0], 32'h100);
      checkOutput("redir_first_instr", obs_instr[0], mem_word(32'h100));
    end

    $display("[TB] redirect coincident with response");
    doReset();
    applyStimulus();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    applyStimulus();
    redirect_valid = 1'b0;
    #1;
    checkOutput("coinc_no_valid0", 32'(id_valid), 32'd0);
    applyStimulus();
    checkOutput("coinc_no_valid1", 32'(id_valid), 32'd0);
    waitObs(1, 20);
    if (obs_pc.size() >= 1) begin
      checkOutput("coinc_pc", obs_pc[0], 32'h80);
      checkOutput("coinc_instr", obs_instr[0], mem_word(32'h80));
    end

    $display("[TB] address wrap");
    doReset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    applyStimulus();
    redirect_valid = 1'b0;
    #1;
    checkOutput("wrap_start_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus();
    checkOutput("wrap_next_addr", imem_addr, 32'h0);
    waitObs(3, 30);
    if (obs_pc.size() >= 3) begin
      checkOutput("wrap_pc0", obs_pc[0], 32'hFFFF_FFFC);
      checkOutput("wrap_pc1", obs_pc[1], 32'h0);
      checkOutput("wrap_pc2", obs_pc[2], 32'h4);
      checkOutput("wrap_instr1", obs_instr[1], mem_word(32'h0));
    end

    $display("[TB] asynchronous reset with full buffer");
    doReset();
    id_ready = 1'b0;
    repeat (4) applyStimulus();
    checkOutput("pre_rst_full", 32'(id_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_id_valid", 32'(id_valid), 32'd0);
    checkOutput("async_imem_req", 32'(imem_req), 32'd0);
    checkOutput("async_id_pc", id_pc, 32'h0);
    memq.delete();
    imem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_req", 32'(imem_req), 32'd1);
    checkOutput("post_rst_addr", imem_addr, 32'h0);
    checkOutput("post_rst_empty", 32'(id_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
